// File: rtl/swin_frame_ram_ctrl.sv
// rtl/swin_frame_ram_ctrl.sv - ping-pong write scheduler from frame concatenator to FFT input RAM
module swin_frame_ram_ctrl #(
    parameter int NP        = 1024,
    parameter int NB_SAMPLE = 16,
    parameter int NB_ADDR   = 11,
    parameter int NB_DROP   = 16
) (
    input  logic                        clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic [2*NP*NB_SAMPLE-1:0]   i_frame,
    input  logic                        i_frame_valid,
    input  logic [1:0]                  i_bank_release,
    output logic                        o_ram_we,
    output logic [NB_ADDR-1:0]          o_ram_addr,
    output logic [2*NB_SAMPLE-1:0]      o_ram_data,
    output logic [1:0]                  o_bank_ready,
    output logic                        o_busy,
    output logic                        o_overflow,
    output logic [NB_DROP-1:0]          o_drop_count
);

    localparam int NB_IDX  = NB_ADDR - 1;
    localparam int NB_FW   = 2 * NP * NB_SAMPLE;
    localparam int NB_FIDX = $clog2(NB_FW);
    localparam int NB_WORD = 2 * NB_SAMPLE;
    localparam logic [NB_FIDX-1:0] IM_OFS   = NB_FIDX'(NP * NB_SAMPLE);
    localparam logic [NB_IDX-1:0]  LAST_IDX = NB_IDX'(NP - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BANK = 2'd1,
        S_WRITE     = 2'd2
    } state_t;

    state_t               state_q;
    logic                 ptr_q;
    logic [NB_IDX-1:0]    idx_q;
    logic [NB_FW-1:0]     frame_q;
    logic                 we_q;
    logic [NB_ADDR-1:0]   addr_q;
    logic [NB_WORD-1:0]   data_q;
    logic [1:0]           ready_q;
    logic                 overflow_q;
    logic [NB_DROP-1:0]   drop_q;

    logic [NB_FIDX-1:0]   cur_base;
    logic [NB_WORD-1:0]   cur_word;
    logic [NB_WORD-1:0]   new_word;
    logic                 drop;

    // Select the {im,re} pair for the next word; word 0 of an incoming frame is taken straight from the input
    always_comb begin
        cur_base = NB_FIDX'(idx_q) * NB_FIDX'(NB_SAMPLE);
        cur_word = {frame_q[cur_base + IM_OFS +: NB_SAMPLE], frame_q[cur_base +: NB_SAMPLE]};
        new_word = {i_frame[NP*NB_SAMPLE +: NB_SAMPLE], i_frame[0 +: NB_SAMPLE]};
        drop     = i_frame_valid && i_enable && (state_q != S_IDLE);
    end

    // Capture / wait-for-bank / serialise FSM with bank ownership and drop accounting
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= 1'b0;
            idx_q      <= '0;
            frame_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ready_q    <= 2'b00;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            overflow_q <= drop;
            if (drop && (drop_q != {NB_DROP{1'b1}})) begin
                drop_q <= drop_q + NB_DROP'(1);
            end
            // releases apply first; a completing write to the same bank overrides below
            ready_q <= ready_q & ~i_bank_release;
            case (state_q)
                S_IDLE: begin
                    we_q <= 1'b0;
                    if (i_enable && i_frame_valid) begin
                        frame_q <= i_frame;
                        if (!ready_q[ptr_q]) begin
                            we_q    <= 1'b1;
                            addr_q  <= {ptr_q, NB_IDX'(0)};
                            data_q  <= new_word;
                            idx_q   <= NB_IDX'(1);
                            state_q <= S_WRITE;
                        end else begin
                            state_q <= S_WAIT_BANK;
                        end
                    end
                end
                S_WAIT_BANK: begin
                    if (!ready_q[ptr_q]) begin
                        // idx_q is 0 here, so cur_word is word 0 of the held frame
                        we_q    <= 1'b1;
                        addr_q  <= {ptr_q, NB_IDX'(0)};
                        data_q  <= cur_word;
                        idx_q   <= NB_IDX'(1);
                        state_q <= S_WRITE;
                    end else begin
                        we_q <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (addr_q[NB_IDX-1:0] == LAST_IDX) begin
                        we_q           <= 1'b0;
                        ready_q[ptr_q] <= 1'b1;
                        ptr_q          <= ~ptr_q;
                        idx_q          <= '0;
                        state_q        <= S_IDLE;
                    end else begin
                        we_q   <= 1'b1;
                        addr_q <= {ptr_q, idx_q};
                        data_q <= cur_word;
                        idx_q  <= idx_q + NB_IDX'(1);
                    end
                end
                default: begin
                    we_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ram_we     = we_q;
    assign o_ram_addr   = addr_q;
    assign o_ram_data   = data_q;
    assign o_bank_ready = ready_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_overflow   = overflow_q;
    assign o_drop_count = drop_q;

endmodule

// File: tb/tb_swin_frame_ram_ctrl.sv
// tb/tb_swin_frame_ram_ctrl.sv - directed self-checking bench for swin_frame_ram_ctrl
module tb_swin_frame_ram_ctrl;

    localparam int NP  = 1024;
    localparam int NBS = 16;
    localparam int NBA = 11;
    localparam int NBD = 16;
    localparam int FW  = 2 * NP * NBS;

    logic              clock = 1'b0;
    logic              i_reset;
    logic              i_enable;
    logic [FW-1:0]     i_frame;
    logic              i_frame_valid;
    logic [1:0]        i_bank_release;
    logic              o_ram_we;
    logic [NBA-1:0]    o_ram_addr;
    logic [2*NBS-1:0]  o_ram_data;
    logic [1:0]        o_bank_ready;
    logic              o_busy;
    logic              o_overflow;
    logic [NBD-1:0]    o_drop_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    swin_frame_ram_ctrl #(
        .NP(NP), .NB_SAMPLE(NBS), .NB_ADDR(NBA), .NB_DROP(NBD)
    ) dut (
        .clock          (clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_frame        (i_frame),
        .i_frame_valid  (i_frame_valid),
        .i_bank_release (i_bank_release),
        .o_ram_we       (o_ram_we),
        .o_ram_addr     (o_ram_addr),
        .o_ram_data     (o_ram_data),
        .o_bank_ready   (o_bank_ready),
        .o_busy         (o_busy),
        .o_overflow     (o_overflow),
        .o_drop_count   (o_drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [15:0] seed, input int k);
        logic [15:0] re;
        logic [15:0] im;
        re = 16'(k) ^ seed;
        im = 16'(-k) ^ seed;
        return {im, re};
    endfunction

    function automatic logic [FW-1:0] make_frame(input logic [15:0] seed);
        logic [FW-1:0] f;
        logic [31:0]   w;
        f = '0;
        for (int k = 0; k < NP; k++) begin
            w = exp_word(seed, k);
            f[k*NBS +: NBS]      = w[15:0];
            f[(NP+k)*NBS +: NBS] = w[31:16];
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] seed);
        i_frame       = make_frame(seed);
        i_frame_valid = 1'b1;
        tick();
        i_frame_valid = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic bank, input logic [15:0] seed, input int k);
        chk(tag, 64'({o_ram_we, o_ram_addr, o_ram_data}),
                 64'({1'b1, bank, 10'(k), exp_word(seed, k)}));
    endtask

    task automatic write_words(input string tag, input logic bank, input logic [15:0] seed);
        for (int k = 0; k < NP; k++) begin
            check_word(tag, bank, seed, k);
            tick();
        end
    endtask

    localparam logic [15:0] SEED_A = 16'h0000;
    localparam logic [15:0] SEED_B = 16'h5A5A;
    localparam logic [15:0] SEED_C = 16'h00F0;
    localparam logic [15:0] SEED_D = 16'hFFFF;
    localparam logic [15:0] SEED_E = 16'h1234;
    localparam logic [15:0] SEED_F = 16'hC3C3;
    localparam logic [15:0] SEED_G = 16'h0F0F;
    localparam logic [15:0] SEED_H = 16'h8001;

    initial begin
        i_reset        = 1'b1;
        i_enable       = 1'b1;
        i_frame        = make_frame(SEED_D);
        i_frame_valid  = 1'b0;
        i_bank_release = 2'b00;

        // 1: reset held three cycles, everything zero
        tick(); tick(); tick();
        chk("rst_we",    64'(o_ram_we),     64'd0);
        chk("rst_addr",  64'(o_ram_addr),   64'd0);
        chk("rst_data",  64'(o_ram_data),   64'd0);
        chk("rst_ready", 64'(o_bank_ready), 64'd0);
        chk("rst_busy",  64'(o_busy),       64'd0);
        chk("rst_ovf",   64'(o_overflow),   64'd0);
        chk("rst_count", 64'(o_drop_count), 64'd0);
        i_reset = 1'b0;

        // 2: first frame re=k im=-k into bank 0, first write one cycle after valid
        send(SEED_A);
        write_words("frameA_word", 1'b0, SEED_A);
        chk("frameA_ready", 64'(o_bank_ready), 64'd1);
        chk("frameA_we_off", 64'(o_ram_we), 64'd0);
        chk("frameA_idle", 64'(o_busy), 64'd0);

        // 3: second frame fills bank 1, no release
        send(SEED_B);
        write_words("frameB_word", 1'b1, SEED_B);
        chk("frameB_ready", 64'(o_bank_ready), 64'd3);

        // 4: third frame waits for bank 0, fourth is dropped
        send(SEED_C);
        chk("wait_busy", 64'(o_busy), 64'd1);
        chk("wait_we", 64'(o_ram_we), 64'd0);
        tick();
        chk("wait_we2", 64'(o_ram_we), 64'd0);
        send(SEED_D);
        chk("drop1_ovf", 64'(o_overflow), 64'd1);
        chk("drop1_count", 64'(o_drop_count), 64'd1);
        chk("drop1_busy", 64'(o_busy), 64'd1);
        tick();
        chk("drop1_ovf_pulse", 64'(o_overflow), 64'd0);
        chk("drop1_we", 64'(o_ram_we), 64'd0);
        i_bank_release = 2'b01;
        tick();
        i_bank_release = 2'b00;
        chk("rel0_ready", 64'(o_bank_ready), 64'd2);
        chk("rel0_we", 64'(o_ram_we), 64'd0);
        tick();
        write_words("frameC_word", 1'b0, SEED_C);
        chk("frameC_ready", 64'(o_bank_ready), 64'd3);

        // 5: drop during WRITE leaves the stream intact; disabled frame is ignored
        i_bank_release = 2'b11;
        tick();
        i_bank_release = 2'b00;
        chk("rel_both", 64'(o_bank_ready), 64'd0);
        send(SEED_E);
        for (int k = 0; k < NP; k++) begin
            check_word("frameE_word", 1'b1, SEED_E, k);
            if (k == 300) begin
                i_frame       = make_frame(SEED_F);
                i_frame_valid = 1'b1;
            end
            if (k == 301) begin
                chk("drop2_ovf", 64'(o_overflow), 64'd1);
                chk("drop2_count", 64'(o_drop_count), 64'd2);
            end
            if (k == 302) begin
                chk("drop2_ovf_pulse", 64'(o_overflow), 64'd0);
            end
            tick();
            if (k == 300) begin
                i_frame_valid = 1'b0;
            end
        end
        chk("frameE_ready", 64'(o_bank_ready), 64'd2);
        i_enable = 1'b0;
        send(SEED_F);
        chk("dis_we", 64'(o_ram_we), 64'd0);
        chk("dis_busy", 64'(o_busy), 64'd0);
        chk("dis_ovf", 64'(o_overflow), 64'd0);
        chk("dis_count", 64'(o_drop_count), 64'd2);
        tick();
        chk("dis_we2", 64'(o_ram_we), 64'd0);
        i_enable = 1'b1;

        // 6: reset mid-write at word 500, then a clean restart in bank 0
        send(SEED_G);
        for (int k = 0; k <= 500; k++) begin
            check_word("frameG_word", 1'b0, SEED_G, k);
            if (k == 500) begin
                i_reset = 1'b1;
            end
            tick();
        end
        i_reset = 1'b0;
        chk("abort_we", 64'(o_ram_we), 64'd0);
        chk("abort_ready", 64'(o_bank_ready), 64'd0);
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_count", 64'(o_drop_count), 64'd0);
        tick();
        chk("abort_we2", 64'(o_ram_we), 64'd0);
        send(SEED_H);
        write_words("frameH_word", 1'b0, SEED_H);
        chk("frameH_ready", 64'(o_bank_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
